// File: rtl/array_unpack_stream_if.sv
// Handshake bundle for array_unpack_stream: packed-word input side and element output side.
// The slave modport is the unpacker's view; master is the view of the logic driving it.
// Index width tracks WA so both ends agree on m_idx/s_lo/s_len widths.
interface array_unpack_stream_if #(
  parameter int WA = 8,
  parameter int WB = 8
);
  localparam int IW = $clog2(WA);

  // packed-word input stream
  logic              s_valid;
  logic              s_ready;
  logic [WA*WB-1:0]  s_data;
  logic [IW-1:0]     s_lo;
  logic [IW-1:0]     s_len;

  // element output stream
  logic              m_valid;
  logic              m_ready;
  logic [WB-1:0]     m_data;
  logic [IW-1:0]     m_idx;
  logic              m_last;

  modport slave (
    input  s_valid, s_data, s_lo, s_len, m_ready,
    output s_ready, m_valid, m_data, m_idx, m_last
  );

  modport master (
    output s_valid, s_data, s_lo, s_len, m_ready,
    input  s_ready, m_valid, m_data, m_idx, m_last
  );
endinterface

// File: rtl/array_unpack_stream.sv
// Unpacks one packed [WA-1:0][WB-1:0] word and streams a contiguous (wrapping) index range, one element per beat.
// Latency: first element 1 clk after the input handshake; back-to-back words with no bubble.
// Backpressure: m_ready low freezes the output beat; s_ready rises only on the accepted last beat or when idle.
// Build option ARRAY_UNPACK_DESCEND_EN walks indices downward from s_lo instead of upward.
module array_unpack_stream #(
  parameter int WA = 8,
  parameter int WB = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  array_unpack_stream_if.slave     bus
);
  localparam int IW = $clog2(WA);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [WA-1:0][WB-1:0]   data_q,  data_d;
  logic [IW-1:0]           idx_q,   idx_d;
  logic [IW-1:0]           rem_q,   rem_d;
  logic [IW-1:0]           idx_step;
  logic                    last;
  logic                    m_fire;
  logic                    s_fire;

  // Index arithmetic wraps for free because WA is a power of two.
`ifdef ARRAY_UNPACK_DESCEND_EN
  assign idx_step = idx_q - IDX_ONE;
`else
  assign idx_step = idx_q + IDX_ONE;
`endif

  assign last        = (rem_q == '0);
  assign m_fire      = (state_q == SEND) && bus.m_ready;
  // s_ready depends only on state and m_ready, never on s_valid.
  assign bus.s_ready = (state_q == IDLE) || (m_fire && last);
  assign s_fire      = bus.s_valid && bus.s_ready;

  assign bus.m_valid = (state_q == SEND);
  assign bus.m_data  = data_q[idx_q];
  assign bus.m_idx   = idx_q;
  assign bus.m_last  = (state_q == SEND) && last;

  // Next state: load on input handshake (covers idle and back-to-back), else advance on accepted beat.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    if (s_fire) begin
      state_d = SEND;
      data_d  = bus.s_data;
      idx_d   = bus.s_lo;
      rem_d   = bus.s_len;
    end else if (m_fire) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_step;
        rem_d = rem_q - IDX_ONE;
      end
    end
  end

  // State register; reset clears the held word so m_data reads zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
    end
  end
endmodule

// File: tb/tb_array_unpack_stream.sv
// Directed bench for array_unpack_stream with WA=WB=8.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// Expected index order follows ARRAY_UNPACK_DESCEND_EN when that macro is defined.
module tb_array_unpack_stream;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  array_unpack_stream_if #(.WA(8), .WB(8)) bus ();

  array_unpack_stream #(.WA(8), .WB(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_idx(input logic [2:0] lo, input int k);
`ifdef ARRAY_UNPACK_DESCEND_EN
    return lo - 3'(k);
`else
    return lo + 3'(k);
`endif
  endfunction

  // Present a word for one cycle; s_lo/s_len are scrambled afterwards to show they are ignored in SEND.
  task automatic load_word(input logic [2:0] lo, input logic [2:0] len, input logic [63:0] data);
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    bus.s_lo    = lo;
    bus.s_len   = len;
    bus.m_ready = 1'b1;
    #1;
    chk("load_s_ready", {63'd0, bus.s_ready}, 64'd1);
    tick();
    bus.s_valid = 1'b0;
    bus.s_lo    = ~lo;
    bus.s_len   = ~len;
  endtask

  // Walk the expected beats; bp applies the m_ready pattern 1,0,0,1 repeating.
  // Element i of the test words is base+i.
  task automatic run_word(input logic [2:0] lo, input logic [2:0] len,
                          input logic [7:0] base, input bit bp);
    logic [3:0] pat;
    logic       rdy;
    logic [2:0] ei;
    int         k;
    int         p;
    pat = 4'b1001;
    k = 0;
    p = 0;
    while (k <= int'(len)) begin
      rdy = bp ? pat[p % 4] : 1'b1;
      p++;
      bus.m_ready = rdy;
      #1;
      ei = exp_idx(lo, k);
      chk("beat_m_valid", {63'd0, bus.m_valid}, 64'd1);
      chk("beat_m_idx",   {61'd0, bus.m_idx},   {61'd0, ei});
      chk("beat_m_data",  {56'd0, bus.m_data},  {56'd0, base + {5'd0, ei}});
      chk("beat_m_last",  {63'd0, bus.m_last},  {63'd0, (k == int'(len))});
      chk("beat_s_ready", {63'd0, bus.s_ready}, {63'd0, rdy && (k == int'(len))});
      tick();
      if (rdy) k++;
    end
    bus.m_ready = 1'b1;
    #1;
    chk("done_m_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("done_s_ready", {63'd0, bus.s_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_lo    = '0;
    bus.s_len   = '0;
    bus.m_ready = 1'b1;

    // Reset held two cycles with m_ready high.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_s_ready", {63'd0, bus.s_ready}, 64'd1);
      chk("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
      chk("rst_m_data",  {56'd0, bus.m_data},  64'd0);
      chk("rst_m_idx",   {61'd0, bus.m_idx},   64'd0);
      chk("rst_m_last",  {63'd0, bus.m_last},  64'd0);
    end
    rst_n = 1'b1;
    tick();

    // Full word, no backpressure.
    load_word(3'd0, 3'd7, 64'h0706050403020100);
    run_word(3'd0, 3'd7, 8'h00, 1'b0);

    // Slice that wraps past the top index.
    load_word(3'd6, 3'd3, 64'h0706050403020100);
    run_word(3'd6, 3'd3, 8'h00, 1'b0);

    // Full word under backpressure.
    load_word(3'd0, 3'd7, 64'h0706050403020100);
    run_word(3'd0, 3'd7, 8'h00, 1'b1);

    // Back-to-back single-element words: AA at idx 2, then 55 at idx 5.
    bus.s_valid = 1'b1;
    bus.s_data  = 64'h0000_0000_00AA_0000;
    bus.s_lo    = 3'd2;
    bus.s_len   = 3'd0;
    bus.m_ready = 1'b1;
    #1;
    chk("b2b_first_s_ready", {63'd0, bus.s_ready}, 64'd1);
    tick();
    bus.s_data = 64'h0000_5500_0000_0000;
    bus.s_lo   = 3'd5;
    #1;
    chk("b2b_a_m_valid", {63'd0, bus.m_valid}, 64'd1);
    chk("b2b_a_m_data",  {56'd0, bus.m_data},  64'hAA);
    chk("b2b_a_m_idx",   {61'd0, bus.m_idx},   64'd2);
    chk("b2b_a_m_last",  {63'd0, bus.m_last},  64'd1);
    chk("b2b_a_s_ready", {63'd0, bus.s_ready}, 64'd1);
    tick();
    bus.s_valid = 1'b0;
    #1;
    chk("b2b_b_m_valid", {63'd0, bus.m_valid}, 64'd1);
    chk("b2b_b_m_data",  {56'd0, bus.m_data},  64'h55);
    chk("b2b_b_m_idx",   {61'd0, bus.m_idx},   64'd5);
    chk("b2b_b_m_last",  {63'd0, bus.m_last},  64'd1);
    tick();
    chk("b2b_done_m_valid", {63'd0, bus.m_valid}, 64'd0);

    // Reset after three accepted beats, then a fresh word starting at its own s_lo.
    load_word(3'd0, 3'd7, 64'h0706050403020100);
    for (int i = 0; i < 3; i++) begin
      chk("mid_m_idx", {61'd0, bus.m_idx}, {61'd0, exp_idx(3'd0, i)});
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("midrst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("midrst_s_ready", {63'd0, bus.s_ready}, 64'd1);
    chk("midrst_m_data",  {56'd0, bus.m_data},  64'd0);
    chk("midrst_m_idx",   {61'd0, bus.m_idx},   64'd0);
    rst_n = 1'b1;
    tick();
    load_word(3'd4, 3'd1, 64'hF7F6F5F4F3F2F1F0);
    run_word(3'd4, 3'd1, 8'hF0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
